// File: rtl/cpu_pkg.sv
// cpu_pkg: shared operation encodings and status bit positions for the register file
package cpu_pkg;
  typedef enum logic [1:0] {SP_HOLD, SP_PUSH, SP_POP, SP_LOAD} sp_op_e;
  typedef enum logic [1:0] {PC_HOLD, PC_INC, PC_LOAD, PC_REL} pc_op_e;
  localparam int FLAG_N = 7;
  localparam int FLAG_V = 6;
  localparam int FLAG_U = 5;
  localparam int FLAG_B = 4;
  localparam int FLAG_D = 3;
  localparam int FLAG_I = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;
  localparam logic [31:0] STATUS_RESET = 32'h24;
endpackage

// File: rtl/pc_next.sv
// pc_next: combinational next program counter for hold, increment, load and relative branch
module pc_next
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic [ADDR_W-1:0] pc,
  input  pc_op_e            pc_op,
  input  logic [ADDR_W-1:0] pc_load,
  input  logic [DATA_W-1:0] pc_offset,
  output logic [ADDR_W-1:0] pc_nxt
);
  logic [ADDR_W-1:0] offset_ext;
  assign offset_ext = {{(ADDR_W-DATA_W){pc_offset[DATA_W-1]}}, pc_offset};
  always_comb
    pc_nxt = pc_op == PC_INC  ? pc + ADDR_W'(1) :
             pc_op == PC_LOAD ? pc_load :
             pc_op == PC_REL  ? pc + ADDR_W'(1) + offset_ext :
                                pc;
endmodule

// File: rtl/cpu_regfile.sv
// cpu_regfile: general registers, stack pointer, program counter and status register
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 16,
  parameter int NUM_GPR = 3,
  parameter logic [DATA_W-1:0]        SP_RESET   = 'hFD,
  parameter logic [ADDR_W-1:0]        PC_RESET   = 'h0000,
  parameter logic [ADDR_W-DATA_W-1:0] STACK_PAGE = 'h01,
  localparam int SEL_W = NUM_GPR > 1 ? $clog2(NUM_GPR) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [SEL_W-1:0]          wr_sel,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      nz_update,
  input  logic [DATA_W-1:0]         flag_we,
  input  logic [DATA_W-1:0]         flag_in,
  input  logic [1:0]                sp_op,
  input  logic [1:0]                pc_op,
  input  logic [ADDR_W-1:0]         pc_load,
  input  logic [DATA_W-1:0]         pc_offset,
  output logic [NUM_GPR*DATA_W-1:0] gpr_flat,
  output logic [DATA_W-1:0]         acc_reg,
  output logic [DATA_W-1:0]         x_reg,
  output logic [DATA_W-1:0]         y_reg,
  output logic [DATA_W-1:0]         sp,
  output logic [ADDR_W-1:0]         stack_addr,
  output logic [ADDR_W-1:0]         pc,
  output logic [DATA_W-1:0]         status_reg
);
  localparam logic [DATA_W-1:0] ST_RST = DATA_W'(STATUS_RESET);
  localparam logic [DATA_W-1:0] ST_ONE = DATA_W'(32'h1 << FLAG_U);
  logic [DATA_W-1:0] gpr_q [NUM_GPR];
  logic [DATA_W-1:0] sp_q, sp_n, st_q, st_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  sp_op_e            sp_sel;
  logic              gpr_wr;
  assign sp_sel = sp_op_e'(sp_op);
  assign gpr_wr = wr_en && (32'(wr_sel) < NUM_GPR);
  pc_next #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pc_next (
    .pc        (pc_q),
    .pc_op     (pc_op_e'(pc_op)),
    .pc_load   (pc_load),
    .pc_offset (pc_offset),
    .pc_nxt    (pc_n)
  );
  always_comb
    sp_n = sp_sel == SP_PUSH ? sp_q - DATA_W'(1) :
           sp_sel == SP_POP  ? sp_q + DATA_W'(1) :
           sp_sel == SP_LOAD ? wr_data :
                               sp_q;
  // N and Z derived from wr_data take priority over the explicit mask
  always_comb begin
    st_n = (st_q & ~flag_we) | (flag_in & flag_we);
    if (nz_update) begin
      st_n[FLAG_N] = wr_data[DATA_W-1];
      st_n[FLAG_Z] = ~|wr_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
      sp_q <= SP_RESET;
      pc_q <= PC_RESET;
      st_q <= ST_RST;
    end else begin
      if (gpr_wr) gpr_q[wr_sel] <= wr_data;
      sp_q <= sp_n;
      pc_q <= pc_n;
      st_q <= st_n;
    end
  end
  for (genvar g = 0; g < NUM_GPR; g++) begin : g_flat
    assign gpr_flat[g*DATA_W +: DATA_W] = gpr_q[g];
  end
  if (NUM_GPR > 0) begin : g_a
    assign acc_reg = gpr_q[0];
  end else begin : g_a0
    assign acc_reg = '0;
  end
  if (NUM_GPR > 1) begin : g_x
    assign x_reg = gpr_q[1];
  end else begin : g_x0
    assign x_reg = '0;
  end
  if (NUM_GPR > 2) begin : g_y
    assign y_reg = gpr_q[2];
  end else begin : g_y0
    assign y_reg = '0;
  end
  assign sp         = sp_q;
  assign stack_addr = {STACK_PAGE, sp_q};
  assign pc         = pc_q;
  assign status_reg = st_q | ST_ONE;
endmodule

// File: tb/tb_cpu_regfile.sv
// tb_cpu_regfile: scoreboard bench for cpu_regfile with directed and random traffic
module tb_cpu_regfile;
  import cpu_pkg::*;
  logic        clk = 0;
  logic        rst, wr_en, nz_update;
  logic [1:0]  wr_sel, sp_op, pc_op;
  logic [7:0]  wr_data, flag_we, flag_in, pc_offset;
  logic [15:0] pc_load;
  logic [23:0] gpr_flat;
  logic [7:0]  acc_reg, x_reg, y_reg, sp, status_reg;
  logic [15:0] stack_addr, pc;
  typedef struct packed {
    logic [7:0]  a, x, y, sp, st;
    logic [15:0] pc;
  } state_t;
  state_t m;
  state_t sb[$];
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  cpu_regfile dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .nz_update(nz_update), .flag_we(flag_we), .flag_in(flag_in), .sp_op(sp_op),
    .pc_op(pc_op), .pc_load(pc_load), .pc_offset(pc_offset), .gpr_flat(gpr_flat),
    .acc_reg(acc_reg), .x_reg(x_reg), .y_reg(y_reg), .sp(sp), .stack_addr(stack_addr),
    .pc(pc), .status_reg(status_reg)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle();
    rst = 0; wr_en = 0; wr_sel = 0; wr_data = 0; nz_update = 0; flag_we = 0;
    flag_in = 0; sp_op = 0; pc_op = 0; pc_load = 0; pc_offset = 0;
  endtask
  // reference model: next architectural state from current model and inputs
  function automatic state_t model(input state_t s);
    state_t e = s;
    if (rst) return '{a: 8'h0, x: 8'h0, y: 8'h0, sp: 8'hFD, st: 8'h24, pc: 16'h0};
    if (wr_en && wr_sel == 2'd0) e.a = wr_data;
    if (wr_en && wr_sel == 2'd1) e.x = wr_data;
    if (wr_en && wr_sel == 2'd2) e.y = wr_data;
    for (int k = 0; k < 8; k++) if (flag_we[k]) e.st[k] = flag_in[k];
    if (nz_update) begin
      e.st[7] = wr_data[7];
      e.st[1] = (wr_data == 8'h00);
    end
    e.st[5] = 1'b1;
    case (sp_op)
      2'd1: e.sp = s.sp - 8'd1;
      2'd2: e.sp = s.sp + 8'd1;
      2'd3: e.sp = wr_data;
      default: ;
    endcase
    case (pc_op)
      2'd1: e.pc = s.pc + 16'd1;
      2'd2: e.pc = pc_load;
      2'd3: e.pc = s.pc + 16'd1 + {{8{pc_offset[7]}}, pc_offset};
      default: ;
    endcase
    return e;
  endfunction
  task automatic cycle();
    state_t e;
    m = model(m);
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("acc", acc_reg, e.a);
    chk("x", x_reg, e.x);
    chk("y", y_reg, e.y);
    chk("flat", gpr_flat, {e.y, e.x, e.a});
    chk("sp", sp, e.sp);
    chk("stack_addr", stack_addr, {8'h01, e.sp});
    chk("pc", pc, e.pc);
    chk("status", status_reg, e.st);
  endtask
  initial begin
    m = '0;
    idle();
    rst = 1;
    cycle();
    chk("rst_a", acc_reg, 8'h00);
    chk("rst_sp", sp, 8'hFD);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_st", status_reg, 8'h24);
    idle(); wr_en = 1; wr_sel = 1; wr_data = 8'h80; nz_update = 1;
    cycle();
    chk("wr_x", x_reg, 8'h80);
    chk("wr_n", status_reg[7], 1'b1);
    chk("wr_z", status_reg[1], 1'b0);
    chk("wr_a_hold", acc_reg, 8'h00);
    idle(); wr_en = 1; wr_sel = 3; wr_data = 8'h55;
    cycle();
    chk("drop_flat", gpr_flat, 24'h008000);
    idle(); sp_op = 2'd3; wr_data = 8'h00;
    cycle();
    idle(); sp_op = 2'd1;
    cycle();
    chk("push_wrap", sp, 8'hFF);
    chk("push_addr", stack_addr, 16'h01FF);
    idle(); sp_op = 2'd2;
    cycle();
    chk("pop_wrap", sp, 8'h00);
    idle(); pc_op = 2'd2; pc_load = 16'h10F0;
    cycle();
    idle(); pc_op = 2'd3; pc_offset = 8'h0E;
    cycle();
    chk("br_fwd", pc, 16'h10FF);
    idle(); pc_op = 2'd2; pc_load = 16'h1000;
    cycle();
    idle(); pc_op = 2'd3; pc_offset = 8'h80;
    cycle();
    chk("br_back", pc, 16'h0F81);
    idle(); pc_op = 2'd2; pc_load = 16'hFFFF;
    cycle();
    idle(); pc_op = 2'd1;
    cycle();
    chk("pc_wrap", pc, 16'h0000);
    idle(); flag_we = 8'h81; flag_in = 8'h01; nz_update = 1; wr_data = 8'h00;
    sp_op = 2'd1; pc_op = 2'd2; pc_load = 16'h8000;
    cycle();
    chk("cc_c", status_reg[0], 1'b1);
    chk("cc_z", status_reg[1], 1'b1);
    chk("cc_n", status_reg[7], 1'b0);
    chk("cc_sp", sp, 8'hFF);
    chk("cc_pc", pc, 16'h8000);
    idle(); flag_we = 8'hFF; flag_in = 8'h00;
    cycle();
    chk("bit5", status_reg, 8'h20);
    idle(); wr_en = 1; wr_sel = 0; wr_data = 8'h5A; sp_op = 2'd3;
    cycle();
    chk("ld_a", acc_reg, 8'h5A);
    chk("ld_sp", sp, 8'h5A);
    idle(); rst = 1; wr_en = 1; wr_sel = 2; wr_data = 8'h77; sp_op = 2'd1;
    pc_op = 2'd2; pc_load = 16'h4321;
    cycle();
    chk("mid_rst_y", y_reg, 8'h00);
    chk("mid_rst_sp", sp, 8'hFD);
    chk("mid_rst_pc", pc, 16'h0000);
    chk("mid_rst_st", status_reg, 8'h24);
    idle(); sp_op = 2'd1; pc_op = 2'd1;
    cycle();
    chk("post_rst_sp", sp, 8'hFC);
    chk("post_rst_pc", pc, 16'h0001);
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      wr_en = 1'($urandom); wr_sel = 2'($urandom); wr_data = 8'($urandom);
      nz_update = 1'($urandom); flag_we = 8'($urandom); flag_in = 8'($urandom);
      sp_op = 2'($urandom); pc_op = 2'($urandom); pc_load = 16'($urandom);
      pc_offset = 8'($urandom);
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
